// File: rtl/mod_mix_columns_pipe_if.sv
// -----------------------------------------------------------------------------
// mod_mix_columns_pipe_if
//
// Purpose : handshake/data bundle for the MixColumns / InvMixColumns engine.
//           The producer/consumer side uses the master modport, the engine
//           uses the slave modport.
//
// Signals :
//   in_valid   producer -> engine  state/inv are valid
//   in_ready   engine -> producer  engine accepts a new state this cycle
//   state      producer -> engine  16-byte input, byte 4c+r = row r, column c
//   inv        producer -> engine  0 = MixColumns, 1 = InvMixColumns
//   state_out  engine -> consumer  result, same byte ordering
//   out_valid  engine -> consumer  state_out holds a complete result
//   out_ready  consumer -> engine  consumer takes the result
//   busy       engine -> observer  engine is transforming column groups
// -----------------------------------------------------------------------------
interface mod_mix_columns_pipe_if;
   localparam int N = 16;

   logic              in_valid;
   logic              in_ready;
   logic [N-1:0][7:0] state;
   logic              inv;
   logic [N-1:0][7:0] state_out;
   logic              out_valid;
   logic              out_ready;
   logic              busy;

   modport master (
      output in_valid, state, inv, out_ready,
      input  in_ready, state_out, out_valid, busy
   );

   modport slave (
      input  in_valid, state, inv, out_ready,
      output in_ready, state_out, out_valid, busy
   );
endinterface

// File: rtl/mod_mix_columns_pipe.sv
// -----------------------------------------------------------------------------
// mod_mix_columns_pipe
//
// Purpose : AES MixColumns / InvMixColumns engine. A 16-byte state is
//           captured on accept and transformed COLS_PER_CYCLE columns per
//           clock, so area (number of column multipliers) can be traded
//           against latency (4/COLS_PER_CYCLE cycles). A valid/ready
//           handshake on both sides lets encrypt and decrypt round
//           controllers share one instance.
//
// Parameters:
//   COLS_PER_CYCLE  columns transformed per cycle: 1, 2 or 4
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-low reset
//   bus    mod_mix_columns_pipe_if.slave (in_valid/in_ready/state/inv,
//          state_out/out_valid/out_ready, busy)
//
// Build option:
//   MIXCOL_INV_EN  when defined, the inverse datapath is built and bus.inv
//                  selects the transform; when undefined, bus.inv is ignored
//                  and the forward transform is always applied.
// -----------------------------------------------------------------------------
module mod_mix_columns_pipe #(
   parameter int COLS_PER_CYCLE = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   mod_mix_columns_pipe_if.slave bus
);

   localparam int N = 16;

   // col_cnt is 2 bits wide; with 4 columns per cycle the step wraps to 0,
   // which makes the single group also the last one.
   localparam logic [1:0] COL_STEP = 2'(COLS_PER_CYCLE);
   localparam logic [1:0] COL_LAST = 2'(4 - COLS_PER_CYCLE);

   if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cfg
      $error("mod_mix_columns_pipe: COLS_PER_CYCLE must be 1, 2 or 4");
   end

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_e;

   // --------------------------------------------------------------------------
   // GF(2^8) helpers, polynomial 0x11B
   // --------------------------------------------------------------------------
   function automatic logic [7:0] xtime(input logic [7:0] x);
      return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
   endfunction

   // Forward column mix; 3a is formed as 2a ^ a.
   function automatic logic [3:0][7:0] mix_fwd(input logic [3:0][7:0] a);
      logic [3:0][7:0] a2;
      logic [3:0][7:0] b;
      for (int r = 0; r < 4; r++) begin
         a2[r] = xtime(a[r]);
      end
      b[0] = a2[0] ^ (a2[1] ^ a[1]) ^ a[2] ^ a[3];
      b[1] = a[0] ^ a2[1] ^ (a2[2] ^ a[2]) ^ a[3];
      b[2] = a[0] ^ a[1] ^ a2[2] ^ (a2[3] ^ a[3]);
      b[3] = (a2[0] ^ a[0]) ^ a[1] ^ a[2] ^ a2[3];
      return b;
   endfunction

`ifdef MIXCOL_INV_EN
   // Inverse column mix; all four coefficients share one xtime chain per byte.
   function automatic logic [3:0][7:0] mix_inv(input logic [3:0][7:0] a);
      logic [3:0][7:0] x2;
      logic [3:0][7:0] x4;
      logic [3:0][7:0] x8;
      logic [3:0][7:0] m9;
      logic [3:0][7:0] mb;
      logic [3:0][7:0] md;
      logic [3:0][7:0] me;
      logic [3:0][7:0] b;
      for (int r = 0; r < 4; r++) begin
         x2[r] = xtime(a[r]);
         x4[r] = xtime(x2[r]);
         x8[r] = xtime(x4[r]);
         m9[r] = x8[r] ^ a[r];
         mb[r] = x8[r] ^ x2[r] ^ a[r];
         md[r] = x8[r] ^ x4[r] ^ a[r];
         me[r] = x8[r] ^ x4[r] ^ x2[r];
      end
      b[0] = me[0] ^ mb[1] ^ md[2] ^ m9[3];
      b[1] = m9[0] ^ me[1] ^ mb[2] ^ md[3];
      b[2] = md[0] ^ m9[1] ^ me[2] ^ mb[3];
      b[3] = mb[0] ^ md[1] ^ m9[2] ^ me[3];
      return b;
   endfunction
`endif

   // --------------------------------------------------------------------------
   // Registers and their next-state values
   // --------------------------------------------------------------------------
   state_e            fsm_q, fsm_d;
   logic [1:0]        col_cnt_q, col_cnt_d;
   logic [N-1:0][7:0] cap_q, cap_d;
   logic [N-1:0][7:0] state_out_q, state_out_d;

   logic              in_ready;
   logic              out_valid;
   logic              busy;
   logic              accept;

   logic [1:0]        col;
   logic [3:0]        col_base;
   logic [3:0][7:0]   col_in;
   logic [3:0][7:0]   col_out;

`ifdef MIXCOL_INV_EN
   logic              inv_q, inv_d;
`else
   // The port stays for interface compatibility but drives nothing.
   logic              inv_unused;
   assign inv_unused = bus.inv;
`endif

   assign accept = bus.in_valid & in_ready;

   // --------------------------------------------------------------------------
   // FSM: state register
   // --------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fsm_q <= S_IDLE;
      end else begin
         fsm_q <= fsm_d;
      end
   end

   // --------------------------------------------------------------------------
   // FSM: next state
   // --------------------------------------------------------------------------
   always_comb begin
      fsm_d = fsm_q;
      case (fsm_q)
         S_IDLE: begin
            if (bus.in_valid) begin
               fsm_d = S_BUSY;
            end
         end
         S_BUSY: begin
            if (col_cnt_q == COL_LAST) begin
               fsm_d = S_DONE;
            end
         end
         S_DONE: begin
            // Back-to-back: a waiting input is taken in the same cycle the
            // result is consumed.
            if (bus.out_ready) begin
               fsm_d = bus.in_valid ? S_BUSY : S_IDLE;
            end
         end
         default: fsm_d = S_IDLE;
      endcase
   end

   // --------------------------------------------------------------------------
   // FSM: outputs
   // --------------------------------------------------------------------------
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      case (fsm_q)
         S_IDLE: in_ready = 1'b1;
         S_BUSY: busy     = 1'b1;
         S_DONE: begin
            out_valid = 1'b1;
            in_ready  = bus.out_ready;
         end
         default: ;
      endcase
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid;
   assign bus.busy      = busy;
   assign bus.state_out = state_out_q;

   // --------------------------------------------------------------------------
   // Datapath next-state: capture on accept, one column group per BUSY cycle
   // --------------------------------------------------------------------------
   always_comb begin
      cap_d       = cap_q;
      col_cnt_d   = col_cnt_q;
      state_out_d = state_out_q;
      col         = 2'd0;
      col_base    = 4'd0;
      col_in      = '0;
      col_out     = '0;
`ifdef MIXCOL_INV_EN
      inv_d       = inv_q;
`endif

      if (accept) begin
         cap_d     = bus.state;
         col_cnt_d = 2'd0;
`ifdef MIXCOL_INV_EN
         inv_d     = bus.inv;
`endif
      end else if (fsm_q == S_BUSY) begin
         for (int g = 0; g < COLS_PER_CYCLE; g++) begin
            col      = col_cnt_q + 2'(g);
            col_base = {col, 2'b00};
            col_in   = cap_q[col_base +: 4];
`ifdef MIXCOL_INV_EN
            col_out  = inv_q ? mix_inv(col_in) : mix_fwd(col_in);
`else
            col_out  = mix_fwd(col_in);
`endif
            state_out_d[col_base +: 4] = col_out;
         end
         col_cnt_d = col_cnt_q + COL_STEP;
      end
   end

   // --------------------------------------------------------------------------
   // Datapath registers
   // --------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         col_cnt_q   <= 2'd0;
         cap_q       <= '0;
         state_out_q <= '0;
      end else begin
         col_cnt_q   <= col_cnt_d;
         cap_q       <= cap_d;
         state_out_q <= state_out_d;
      end
   end

`ifdef MIXCOL_INV_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         inv_q <= 1'b0;
      end else begin
         inv_q <= inv_d;
      end
   end
`endif

endmodule

// File: tb/tb_mod_mix_columns_pipe.sv
module tb_mod_mix_columns_pipe;

   localparam int NDUT = 3;   // instance k uses COLS_PER_CYCLE = 1 << k

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic [NDUT-1:0] in_valid;
   logic [NDUT-1:0] inv_in;
   logic [NDUT-1:0] out_ready;
   logic [NDUT-1:0] in_ready;
   logic [NDUT-1:0] out_valid;
   logic [NDUT-1:0] busy;
   logic [15:0][7:0] st_in  [NDUT];
   logic [15:0][7:0] st_out [NDUT];

   int n_chk  = 0;
   int n_fail = 0;

   for (genvar k = 0; k < NDUT; k++) begin : g_dut
      mod_mix_columns_pipe_if bus ();
      mod_mix_columns_pipe #(.COLS_PER_CYCLE(1 << k)) dut (
         .clk   (clk),
         .reset (reset),
         .bus   (bus)
      );
      assign bus.in_valid  = in_valid[k];
      assign bus.state     = st_in[k];
      assign bus.inv       = inv_in[k];
      assign bus.out_ready = out_ready[k];
      assign in_ready[k]   = bus.in_ready;
      assign out_valid[k]  = bus.out_valid;
      assign busy[k]       = bus.busy;
      assign st_out[k]     = bus.state_out;
   end

   // ---------------- reference model ----------------
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [15:0] p;
      p = 16'h0;
      for (int i = 0; i < 8; i++)
         if (b[i]) p = p ^ (16'(a) << i);
      for (int i = 15; i >= 8; i--)
         if (p[i]) p = p ^ (16'h011b << (i - 8));
      return p[7:0];
   endfunction

   function automatic logic eff_inv(input logic iv);
`ifdef MIXCOL_INV_EN
      return iv;
`else
      return 1'b0 & iv;
`endif
   endfunction

   function automatic logic [15:0][7:0] ref_mix(input logic [15:0][7:0] s, input logic iv);
      logic [3:0][7:0] base;
      logic [15:0][7:0] res;
      logic [7:0] acc;
      base = iv ? {8'h09, 8'h0d, 8'h0b, 8'h0e} : {8'h01, 8'h01, 8'h03, 8'h02};
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++) begin
            acc = 8'h00;
            for (int j = 0; j < 4; j++)
               acc = acc ^ gmul(base[(j - r + 4) % 4], s[4*c + j]);
            res[4*c + r] = acc;
         end
      return res;
   endfunction

   // byte 0 is the leftmost byte of the literal
   function automatic logic [15:0][7:0] from_be(input logic [127:0] v);
      logic [15:0][7:0] s;
      for (int i = 0; i < 16; i++) s[i] = v[127 - 8*i -: 8];
      return s;
   endfunction

   // ---------------- helpers ----------------
   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // From just after an accept edge, wait (bounded) for out_valid.
   task automatic wait_result(input int k, output int lat, output int bcnt);
      lat  = 0;
      bcnt = 0;
      while (!out_valid[k] && lat < 20) begin
         if (busy[k]) bcnt++;
         tick();
         lat++;
      end
   endtask

   // Full transfer; inputs are scrambled right after accept.
   task automatic xfer(input int k, input logic [15:0][7:0] s, input logic iv,
                       output logic [15:0][7:0] res, output int lat, output int bcnt);
      int guard;
      guard = 0;
      while (!in_ready[k] && guard < 20) begin
         tick();
         guard++;
      end
      chk($sformatf("d%0d_in_ready_before_accept", k), 128'(in_ready[k]), 128'(1));
      st_in[k]    = s;
      inv_in[k]   = iv;
      in_valid[k] = 1'b1;
      tick();
      in_valid[k] = 1'b0;
      st_in[k]    = {$urandom, $urandom, $urandom, $urandom};
      inv_in[k]   = ~iv;
      wait_result(k, lat, bcnt);
      res = st_out[k];
   endtask

   // ---------------- directed sequence ----------------
   logic [15:0][7:0] vin, vout, s, s2, res, held, exp;
   logic iv, iv2;
   int lat, bcnt;

   initial begin
      reset     = 1'b0;
      in_valid  = '0;
      inv_in    = '0;
      out_ready = '1;
      for (int k = 0; k < NDUT; k++) st_in[k] = '0;
      vin  = from_be(128'hdb135345_f20a225c_d4d4d4d5_2d26314c);
      vout = from_be(128'h8e4da1bc_9fdc589d_d5d5d7d6_4d7ebdf8);

      // reset state
      repeat (3) @(posedge clk);
      #1;
      for (int k = 0; k < NDUT; k++) begin
         chk($sformatf("d%0d_rst_state_out", k), st_out[k], 128'h0);
         chk($sformatf("d%0d_rst_out_valid", k), 128'(out_valid[k]), 128'(0));
         chk($sformatf("d%0d_rst_busy", k), 128'(busy[k]), 128'(0));
      end
      @(negedge clk);
      reset = 1'b1;
      tick();
      for (int k = 0; k < NDUT; k++)
         chk($sformatf("d%0d_post_rst_in_ready", k), 128'(in_ready[k]), 128'(1));

      // known forward vector, 4 columns per cycle
      xfer(2, vin, 1'b0, res, lat, bcnt);
      chk("fwd_vec_result", res, vout);
      chk("fwd_vec_latency", 128'(lat), 128'(1));

      // inverse of the forward output
      xfer(2, vout, 1'b1, res, lat, bcnt);
`ifdef MIXCOL_INV_EN
      exp = vin;
`else
      exp = ref_mix(vout, 1'b0);
`endif
      chk("inv_vec_result", res, exp);

      // identity columns, one column per cycle
      for (int t = 0; t < 2; t++) begin
         s = (t == 0) ? {16{8'h01}} : {16{8'hc6}};
         xfer(0, s, 1'b0, res, lat, bcnt);
         chk($sformatf("ident%0d_result", t), res, s);
         chk($sformatf("ident%0d_latency", t), 128'(lat), 128'(4));
         chk($sformatf("ident%0d_busy_cycles", t), 128'(bcnt), 128'(4));
      end

      // randomized transfers on every width
      for (int k = 0; k < NDUT; k++)
         for (int t = 0; t < 6; t++) begin
            s  = {$urandom, $urandom, $urandom, $urandom};
            iv = 1'($urandom_range(0, 1));
            xfer(k, s, iv, res, lat, bcnt);
            chk($sformatf("d%0d_rand%0d_result", k, t), res, ref_mix(s, eff_inv(iv)));
            chk($sformatf("d%0d_rand%0d_latency", k, t), 128'(lat), 128'(4 >> k));
         end

      // backpressure then same-cycle accept, on widths 1 and 4
      for (int k = 0; k < NDUT; k += 2) begin
         out_ready[k] = 1'b0;
         s  = {$urandom, $urandom, $urandom, $urandom};
         iv = 1'($urandom_range(0, 1));
         xfer(k, s, iv, held, lat, bcnt);
         chk($sformatf("d%0d_bp_result", k), held, ref_mix(s, eff_inv(iv)));
         for (int c = 0; c < 5; c++) begin
            tick();
            chk($sformatf("d%0d_bp_hold%0d_data", k, c), st_out[k], held);
            chk($sformatf("d%0d_bp_hold%0d_in_ready", k, c), 128'(in_ready[k]), 128'(0));
            chk($sformatf("d%0d_bp_hold%0d_out_valid", k, c), 128'(out_valid[k]), 128'(1));
         end
         s2  = {$urandom, $urandom, $urandom, $urandom};
         iv2 = 1'($urandom_range(0, 1));
         out_ready[k] = 1'b1;
         in_valid[k]  = 1'b1;
         st_in[k]     = s2;
         inv_in[k]    = iv2;
         #1;
         chk($sformatf("d%0d_b2b_in_ready", k), 128'(in_ready[k]), 128'(1));
         tick();
         in_valid[k] = 1'b0;
         st_in[k]    = ~s2;
         inv_in[k]   = ~iv2;
         wait_result(k, lat, bcnt);
         chk($sformatf("d%0d_b2b_result", k), st_out[k], ref_mix(s2, eff_inv(iv2)));
         chk($sformatf("d%0d_b2b_latency", k), 128'(lat), 128'(4 >> k));
      end

      // asynchronous reset after two column groups, one column per cycle
      tick();
      s = {$urandom, $urandom, $urandom, $urandom};
      st_in[0]    = s;
      inv_in[0]   = 1'b0;
      in_valid[0] = 1'b1;
      tick();
      in_valid[0] = 1'b0;
      tick();
      tick();
      chk("abort_busy_before_reset", 128'(busy[0]), 128'(1));
      reset = 1'b0;
      #1;
      chk("abort_state_out", st_out[0], 128'h0);
      chk("abort_out_valid", 128'(out_valid[0]), 128'(0));
      chk("abort_busy", 128'(busy[0]), 128'(0));
      @(negedge clk);
      reset = 1'b1;
      tick();
      tick();
      chk("abort_no_stale_output", 128'(out_valid[0]), 128'(0));
      s  = {$urandom, $urandom, $urandom, $urandom};
      iv = 1'($urandom_range(0, 1));
      xfer(0, s, iv, res, lat, bcnt);
      chk("after_abort_result", res, ref_mix(s, eff_inv(iv)));
      chk("after_abort_latency", 128'(lat), 128'(4));

      tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
